// File: rtl/stack_pkg.sv
// Shared definitions for the data-stack controller and its depth tracker.
//   WIDTH_DEF / DEPTH_DEF : default cell width and entry count
//   D_*                   : 2-bit two's-complement stack pointer deltas
//   dbg_op_t              : debug requester opcodes
//   state_t               : debug sequencer FSM states
package stack_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 32;

  localparam logic [1:0] D_NONE = 2'b00;
  localparam logic [1:0] D_PUSH = 2'b01;
  localparam logic [1:0] D_POP  = 2'b11;
  localparam logic [1:0] D_POP2 = 2'b10;

  typedef enum logic [1:0] {
    OP_PEEK = 2'b00,
    OP_PUSH = 2'b01,
    OP_REPL = 2'b10,
    OP_POP  = 2'b11
  } dbg_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_ACK,
    S_WAIT
  } state_t;

endpackage

// File: rtl/stack_depth.sv
// Saturating stack depth counter with sticky overflow/underflow flags.
//   clk, reset : clock, asynchronous active-high reset
//   delta      : applied pointer delta (two's complement, -2..+1)
//   flag_clr   : synchronous clear of ovf/unf (a same-cycle error wins)
//   depth      : net entries, 0..DEPTH
//   ovf, unf   : sticky overflow / underflow
import stack_pkg::*;

module stack_depth #(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               delta,
  input  logic                     flag_clr,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     ovf,
  output logic                     unf
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam logic signed [DW:0] DMAX = (DW+1)'(DEPTH);

  logic signed [DW:0] sum;
  logic               hi;
  logic               lo;
  logic [DW-1:0]      depth_nxt;

  // One extra bit so the sum can go negative or past DEPTH before clamping.
  always_comb begin
    sum = $signed({1'b0, depth}) + $signed({{(DW-1){delta[1]}}, delta});
    hi  = (sum > DMAX);
    lo  = sum[DW];
    if (hi)
      depth_nxt = DMAX[DW-1:0];
    else if (lo)
      depth_nxt = '0;
    else
      depth_nxt = sum[DW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      depth <= depth_nxt;
      if (hi)
        ovf <= 1'b1;
      else if (flag_clr)
        ovf <= 1'b0;
      if (lo)
        unf <= 1'b1;
      else if (flag_clr)
        unf <= 1'b0;
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// Data-stack sequencer/arbiter between the CPU core and the block-RAM stack.
// CPU traffic passes straight through; a debug requester gets one exclusive
// push/pop/peek/replace per request level while the CPU is stalled 2 cycles.
//   cpu_we/cpu_delta/cpu_wd : CPU stack request; cpu_stall holds the CPU
//   stk_we/stk_delta/stk_wd : to stack; stk_rd is the combinational NOS
//   dbg_req/dbg_op/dbg_wd   : debug request (level), opcode, write data
//   dbg_ack, dbg_rd         : completion pulse, captured NOS for peek/pop
//   depth, ovf, unf         : accounting; flag_clr clears ovf/unf
import stack_pkg::*;

module stack_ctrl #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_we,
  input  logic [1:0]             cpu_delta,
  input  logic [WIDTH-1:0]       cpu_wd,
  output logic                   cpu_stall,
  output logic                   stk_we,
  output logic [1:0]             stk_delta,
  output logic [WIDTH-1:0]       stk_wd,
  input  logic [WIDTH-1:0]       stk_rd,
  input  logic                   dbg_req,
  input  logic [1:0]             dbg_op,
  input  logic [WIDTH-1:0]       dbg_wd,
  output logic                   dbg_ack,
  output logic [WIDTH-1:0]       dbg_rd,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   ovf,
  output logic                   unf,
  input  logic                   flag_clr
);

  state_t state, state_nxt;
  logic   capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (dbg_req) state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_ACK;
      S_ACK:  state_nxt = dbg_req ? S_WAIT : S_IDLE;
      S_WAIT: if (!dbg_req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stk_we    = cpu_we;
    stk_delta = cpu_delta;
    stk_wd    = cpu_wd;
    cpu_stall = 1'b0;
    dbg_ack   = 1'b0;
    capture   = 1'b0;
    case (state)
      S_EXEC: begin
        cpu_stall = 1'b1;
        stk_wd    = dbg_wd;
        case (dbg_op_t'(dbg_op))
          OP_PEEK: begin stk_we = 1'b0; stk_delta = D_NONE; capture = 1'b1; end
          OP_PUSH: begin stk_we = 1'b1; stk_delta = D_PUSH; end
          OP_POP:  begin stk_we = 1'b0; stk_delta = D_POP;  capture = 1'b1; end
          OP_REPL: begin stk_we = 1'b1; stk_delta = D_NONE; end
          default: begin stk_we = 1'b0; stk_delta = D_NONE; end
        endcase
      end
      S_ACK: begin
        cpu_stall = 1'b1;
        stk_we    = 1'b0;
        stk_delta = D_NONE;
        dbg_ack   = 1'b1;
      end
      default: ;
    endcase
  end

  // NOS is read before the pop's pointer move takes effect at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dbg_rd <= '0;
    else if (capture)
      dbg_rd <= stk_rd;
  end

  stack_depth #(.DEPTH(DEPTH)) u_depth (
    .clk      (clk),
    .reset    (reset),
    .delta    (stk_delta),
    .flag_clr (flag_clr),
    .depth    (depth),
    .ovf      (ovf),
    .unf      (unf)
  );

endmodule

// File: tb/tb_stack_ctrl.sv
import stack_pkg::*;

module tb_stack_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [1:0]  cpu_delta;
  logic [15:0] cpu_wd;
  logic        cpu_stall;
  logic        stk_we;
  logic [1:0]  stk_delta;
  logic [15:0] stk_wd;
  logic [15:0] stk_rd;
  logic        dbg_req;
  logic [1:0]  dbg_op;
  logic [15:0] dbg_wd;
  logic        dbg_ack;
  logic [15:0] dbg_rd;
  logic [5:0]  depth;
  logic        ovf;
  logic        unf;
  logic        flag_clr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stack_ctrl #(.WIDTH(16), .DEPTH(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_delta(cpu_delta), .cpu_wd(cpu_wd), .cpu_stall(cpu_stall),
    .stk_we(stk_we), .stk_delta(stk_delta), .stk_wd(stk_wd), .stk_rd(stk_rd),
    .dbg_req(dbg_req), .dbg_op(dbg_op), .dbg_wd(dbg_wd), .dbg_ack(dbg_ack), .dbg_rd(dbg_rd),
    .depth(depth), .ovf(ovf), .unf(unf), .flag_clr(flag_clr)
  );

  // Block-RAM stack environment: write lands at the new pointer, NOS = mem[sp].
  logic [15:0] mem [32];
  logic [4:0]  sp;
  logic [4:0]  sp_n;
  assign sp_n   = sp + {{3{stk_delta[1]}}, stk_delta};
  assign stk_rd = mem[sp];
  always @(posedge clk or posedge reset) begin
    if (reset) sp <= 5'd0;
    else begin
      if (stk_we) mem[sp_n] <= stk_wd;
      sp <= sp_n;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  d;
    logic [15:0] wd;
    logic        req;
    logic [1:0]  op;
    logic [15:0] dwd;
    logic        clr;
    logic        e_stall;
    logic        e_ack;
    logic        e_swe;
    logic [1:0]  e_sd;
    logic [15:0] e_swd;
    logic        c_wd;
    logic [5:0]  e_depth;
    logic        e_ovf;
    logic        e_unf;
    logic [15:0] e_rd;
  } vec_t;

  vec_t v [26];

  task automatic nop_cpu();
    cpu_we = 1'b0; cpu_delta = D_NONE; cpu_wd = 16'h0000; flag_clr = 1'b0;
  endtask

  initial begin
    int acks;
    logic [5:0] ed;

    //        we    d      wd        req   op       dwd       clr   stall ack   swe   sd     swd       cwd   depth  ovf   unf   rd
    v[0]  = '{1'b1, D_PUSH, 16'h1111, 1'b0, OP_PEEK, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, D_PUSH, 16'h1111, 1'b1, 6'd1, 1'b0, 1'b0, 16'h0000};
    v[1]  = '{1'b1, D_PUSH, 16'h2222, 1'b0, OP_PEEK, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, D_PUSH, 16'h2222, 1'b1, 6'd2, 1'b0, 1'b0, 16'h0000};
    v[2]  = '{1'b1, D_PUSH, 16'h3333, 1'b0, OP_PEEK, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, D_PUSH, 16'h3333, 1'b1, 6'd3, 1'b0, 1'b0, 16'h0000};
    v[3]  = '{1'b0, D_NONE, 16'h0000, 1'b1, OP_POP,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, D_NONE, 16'h0000, 1'b1, 6'd3, 1'b0, 1'b0, 16'h0000};
    v[4]  = '{1'b1, D_PUSH, 16'h9999, 1'b1, OP_POP,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, D_POP,  16'h0000, 1'b0, 6'd2, 1'b0, 1'b0, 16'h3333};
    v[5]  = '{1'b1, D_PUSH, 16'h9999, 1'b0, OP_POP,  16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, D_NONE, 16'h0000, 1'b0, 6'd2, 1'b0, 1'b0, 16'h3333};
    v[6]  = '{1'b0, D_NONE, 16'h0000, 1'b1, OP_PEEK, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, D_NONE, 16'h0000, 1'b1, 6'd2, 1'b0, 1'b0, 16'h3333};
    v[7]  = '{1'b0, D_NONE, 16'h0000, 1'b1, OP_PEEK, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, D_NONE, 16'h0000, 1'b0, 6'd2, 1'b0, 1'b0, 16'h2222};
    v[8]  = '{1'b0, D_NONE, 16'h0000, 1'b0, OP_PEEK, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, D_NONE, 16'h0000, 1'b0, 6'd2, 1'b0, 1'b0, 16'h2222};
    v[9]  = '{1'b0, D_NONE, 16'h0000, 1'b1, OP_REPL, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, D_NONE, 16'h0000, 1'b1, 6'd2, 1'b0, 1'b0, 16'h2222};
    v[10] = '{1'b0, D_NONE, 16'h0000, 1'b1, OP_REPL, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b1, D_NONE, 16'hBEEF, 1'b1, 6'd2, 1'b0, 1'b0, 16'h2222};
    v[11] = '{1'b0, D_NONE, 16'h0000, 1'b0, OP_REPL, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0, D_NONE, 16'h0000, 1'b0, 6'd2, 1'b0, 1'b0, 16'h2222};
    v[12] = '{1'b0, D_NONE, 16'h0000, 1'b1, OP_PEEK, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, D_NONE, 16'h0000, 1'b1, 6'd2, 1'b0, 1'b0, 16'h2222};
    v[13] = '{1'b0, D_NONE, 16'h0000, 1'b1, OP_PEEK, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, D_NONE, 16'h0000, 1'b0, 6'd2, 1'b0, 1'b0, 16'hBEEF};
    v[14] = '{1'b0, D_NONE, 16'h0000, 1'b0, OP_PEEK, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, D_NONE, 16'h0000, 1'b0, 6'd2, 1'b0, 1'b0, 16'hBEEF};
    v[15] = '{1'b1, D_PUSH, 16'h5555, 1'b1, OP_PUSH, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b1, D_PUSH, 16'h5555, 1'b1, 6'd3, 1'b0, 1'b0, 16'hBEEF};
    v[16] = '{1'b0, D_POP,  16'h7777, 1'b1, OP_PUSH, 16'h4444, 1'b0, 1'b1, 1'b0, 1'b1, D_PUSH, 16'h4444, 1'b1, 6'd4, 1'b0, 1'b0, 16'hBEEF};
    v[17] = '{1'b0, D_NONE, 16'h0000, 1'b0, OP_PUSH, 16'h4444, 1'b0, 1'b1, 1'b1, 1'b0, D_NONE, 16'h0000, 1'b0, 6'd4, 1'b0, 1'b0, 16'hBEEF};
    v[18] = '{1'b0, D_NONE, 16'h0000, 1'b1, OP_POP,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, D_NONE, 16'h0000, 1'b1, 6'd4, 1'b0, 1'b0, 16'hBEEF};
    v[19] = '{1'b0, D_NONE, 16'h0000, 1'b1, OP_POP,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, D_POP,  16'h0000, 1'b0, 6'd3, 1'b0, 1'b0, 16'h4444};
    v[20] = '{1'b0, D_NONE, 16'h0000, 1'b0, OP_POP,  16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, D_NONE, 16'h0000, 1'b0, 6'd3, 1'b0, 1'b0, 16'h4444};
    v[21] = '{1'b0, D_POP2, 16'h0000, 1'b0, OP_PEEK, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, D_POP2, 16'h0000, 1'b1, 6'd1, 1'b0, 1'b0, 16'h4444};
    v[22] = '{1'b0, D_POP,  16'h0000, 1'b0, OP_PEEK, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, D_POP,  16'h0000, 1'b1, 6'd0, 1'b0, 1'b0, 16'h4444};
    v[23] = '{1'b0, D_POP,  16'h0000, 1'b0, OP_PEEK, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, D_POP,  16'h0000, 1'b1, 6'd0, 1'b0, 1'b1, 16'h4444};
    v[24] = '{1'b0, D_POP,  16'h0000, 1'b0, OP_PEEK, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, D_POP,  16'h0000, 1'b1, 6'd0, 1'b0, 1'b1, 16'h4444};
    v[25] = '{1'b0, D_NONE, 16'h0000, 1'b0, OP_PEEK, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, D_NONE, 16'h0000, 1'b1, 6'd0, 1'b0, 1'b0, 16'h4444};

    reset = 1'b1;
    nop_cpu();
    dbg_req = 1'b0; dbg_op = OP_PEEK; dbg_wd = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(cpu_stall), 32'(0));
    chk("rst_ack",   32'(dbg_ack),   32'(0));
    chk("rst_depth", 32'(depth),     32'(0));
    chk("rst_ovf",   32'(ovf),       32'(0));
    chk("rst_unf",   32'(unf),       32'(0));
    chk("rst_rd",    32'(dbg_rd),    32'(0));
    reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      cpu_we = v[i].we; cpu_delta = v[i].d; cpu_wd = v[i].wd;
      dbg_req = v[i].req; dbg_op = v[i].op; dbg_wd = v[i].dwd; flag_clr = v[i].clr;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(v[i].e_stall));
      chk($sformatf("v%0d_ack", i),   32'(dbg_ack),   32'(v[i].e_ack));
      chk($sformatf("v%0d_swe", i),   32'(stk_we),    32'(v[i].e_swe));
      chk($sformatf("v%0d_sdelta", i), 32'(stk_delta), 32'(v[i].e_sd));
      if (v[i].c_wd) chk($sformatf("v%0d_swd", i), 32'(stk_wd), 32'(v[i].e_swd));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_depth", i), 32'(depth),  32'(v[i].e_depth));
      chk($sformatf("v%0d_ovf", i),   32'(ovf),    32'(v[i].e_ovf));
      chk($sformatf("v%0d_unf", i),   32'(unf),    32'(v[i].e_unf));
      chk($sformatf("v%0d_rd", i),    32'(dbg_rd), 32'(v[i].e_rd));
    end

    // 33 pushes from depth 0: saturate at 32, overflow on the last one.
    dbg_req = 1'b0;
    nop_cpu();
    for (int i = 0; i < 33; i++) begin
      cpu_we = 1'b1; cpu_delta = D_PUSH; cpu_wd = 16'(i);
      @(posedge clk);
      #1;
      ed = (i >= 31) ? 6'd32 : 6'(i + 1);
      chk($sformatf("ovf_push%0d_depth", i), 32'(depth), 32'(ed));
      chk($sformatf("ovf_push%0d_ovf", i),   32'(ovf),   32'((i == 32) ? 1 : 0));
    end
    cpu_we = 1'b0; cpu_delta = D_POP2;
    @(posedge clk); #1;
    chk("pop2_depth", 32'(depth), 32'(30));
    chk("pop2_ovf",   32'(ovf),   32'(1));
    nop_cpu(); flag_clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_ovf",   32'(ovf),   32'(0));
    chk("clr_depth", 32'(depth), 32'(30));
    flag_clr = 1'b0;

    // Request held for 10 cycles: one op, then WAIT with no further grant.
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      nop_cpu(); dbg_req = 1'b1; dbg_op = OP_PEEK;
      #1;
      chk($sformatf("hold%0d_stall", i), 32'(cpu_stall), 32'((i == 1 || i == 2) ? 1 : 0));
      chk($sformatf("hold%0d_ack", i),   32'(dbg_ack),   32'((i == 2) ? 1 : 0));
      if (dbg_ack) acks++;
      @(posedge clk); #1;
    end
    chk("hold_ack_count", 32'(acks), 32'(1));
    dbg_req = 1'b0;
    #1;
    chk("wait_release_stall", 32'(cpu_stall), 32'(0));
    @(posedge clk); #1;
    dbg_req = 1'b1;
    #1;
    chk("idle_again_stall", 32'(cpu_stall), 32'(0));
    @(posedge clk); #1;
    #1;
    chk("exec_again_stall", 32'(cpu_stall), 32'(1));

    // Asynchronous reset during EXEC aborts the op with no ack.
    cpu_we = 1'b1; cpu_delta = D_PUSH; cpu_wd = 16'hABCD; dbg_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_stall",  32'(cpu_stall), 32'(0));
    chk("arst_ack",    32'(dbg_ack),   32'(0));
    chk("arst_depth",  32'(depth),     32'(0));
    chk("arst_ovf",    32'(ovf),       32'(0));
    chk("arst_unf",    32'(unf),       32'(0));
    chk("arst_rd",     32'(dbg_rd),    32'(0));
    chk("arst_swe",    32'(stk_we),    32'(1));
    chk("arst_sdelta", 32'(stk_delta), 32'(1));
    chk("arst_swd",    32'(stk_wd),    32'(16'hABCD));
    @(posedge clk); #1;
    reset = 1'b0;
    nop_cpu();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("post_rst%0d_ack", i),   32'(dbg_ack),   32'(0));
      chk($sformatf("post_rst%0d_stall", i), 32'(cpu_stall), 32'(0));
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Sequencer and arbiter placed between the CPU core and the 32-entry block-RAM data stack (one write enable, 2-bit signed pointer delta, write data, combinational NOS read). It passes CPU stack traffic through and tracks stack depth with sticky overflow/underflow flags. It also grants a debug/monitor requester exclusive stack access by stalling the CPU while a single debug push, pop, peek or replace executes.

## Interface
Parameters:
- WIDTH, 16, stack cell width
- DEPTH, 32, stack entries; must equal 2^(stack pointer width)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- cpu_we  in  1  CPU stack write request
- cpu_delta  in  2  CPU pointer delta, two's complement (00=0, 01=+1, 11=-1, 10=-2)
- cpu_wd  in  WIDTH  CPU write data
- cpu_stall  out  1  CPU must hold its state; its stack inputs are ignored
- stk_we  out  1  to stack write enable
- stk_delta  out  2  to stack delta
- stk_wd  out  WIDTH  to stack write data
- stk_rd  in  WIDTH  stack NOS (combinational from current pointer)
- dbg_req  in  1  debug request, level
- dbg_op  in  2  00=peek, 01=push, 11=pop, 10=replace NOS
- dbg_wd  in  WIDTH  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rd  out  WIDTH  captured NOS for peek/pop
- depth  out  $clog2(DEPTH)+1  net entries, 0..DEPTH
- ovf  out  1  sticky overflow
- unf  out  1  sticky underflow
- flag_clr  in  1  synchronous clear of ovf/unf

## Operation
- FSM states: IDLE, EXEC, ACK, WAIT. Registered state; all stall/mux controls are Moore-decoded from state.
- IDLE: stk_* = cpu_*; cpu_stall=0. If dbg_req=1, next state EXEC. The CPU op in that same cycle still executes.
- EXEC: cpu_stall=1; stk_* driven from debug op:
  - peek: we=0, delta=00; dbg_rd<=stk_rd.
  - push: we=1, delta=01, wd=dbg_wd.
  - pop: we=0, delta=11; dbg_rd<=stk_rd (value before the move).
  - replace: we=1, delta=00, wd=dbg_wd (overwrites NOS in place).
  - Next state: ACK.
- ACK: cpu_stall=1, stk_we=0, stk_delta=00, dbg_ack=1. Next state: WAIT if dbg_req=1, else IDLE.
- WAIT: cpu_stall=0, pass-through as in IDLE, no grant. Return to IDLE once dbg_req=0. Each request level therefore yields exactly one op.
- dbg_op and dbg_wd are sampled only in EXEC; the requester holds them stable from req rise until ack.
- Depth accounting applies to every effective stk_delta (CPU or debug): depth_next = depth + sext(delta).
  - Result > DEPTH: depth saturates at DEPTH, ovf<=1.
  - Result < 0: depth saturates at 0, unf<=1.
  - Saturation affects accounting only; the physical pointer wraps mod DEPTH regardless.
- flag_clr clears ovf/unf. A simultaneous new error event wins: the flag stays 1. Depth is unaffected by flag_clr.

## Timing
- Reset values: state=IDLE, cpu_stall=0, dbg_ack=0, dbg_rd=0, depth=0, ovf=0, unf=0. stk_* follow cpu_* (pass-through).
- Reset mid-EXEC/ACK aborts immediately with no ack. The stack memory and pointer are not reset; depth restarts at 0 and is relative from then on.
- Debug latency: req high at edge N → EXEC cycle N+1 → dbg_ack high in cycle N+2. dbg_rd is valid from N+2 and held until the next peek/pop.
- CPU stall is exactly 2 cycles per debug op.
- depth, ovf and unf update on the edge ending the cycle in which the delta is applied.
- Pass-through path is combinational: cpu_* to stk_* adds zero latency.

## Structure
- Shared package stack_pkg:
  - WIDTH and DEPTH defaults
  - delta encodings (D_NONE, D_PUSH, D_POP, D_POP2)
  - debug opcodes (OP_PEEK, OP_PUSH, OP_POP, OP_REPL)
  - FSM state enum
- Sub-module stack_depth: saturating depth counter plus sticky ovf/unf with flag_clr. Reused later for the return stack.
- Top level holds the FSM, the output mux and the dbg_rd register.

## Test plan
- CPU pushes 0x1111, 0x2222, 0x3333 (delta 01, we=1) → depth=3; stk_* mirrors cpu_* same cycle; cpu_stall=0 throughout.
- After the above, debug pop → cpu_stall high 2 cycles, dbg_ack at N+2, dbg_rd=0x3333, depth=2; debug peek → dbg_rd=0x2222, depth=2.
- Debug replace with 0xBEEF, then peek → dbg_rd=0xBEEF, depth unchanged.
- From depth=0, CPU delta=11 → depth=0, unf=1; flag_clr asserted together with another delta=11 → unf stays 1; flag_clr alone → unf=0.
- 33 pushes from depth 0 → depth=32, ovf=1 on the 33rd; then delta=10 → depth=30.
- dbg_req held high for 10 cycles → exactly one ack, WAIT entered; reset asserted in an EXEC cycle → no ack, all outputs at reset values asynchronously.
